// File: rtl/button_debouncer.sv
// Active-low pushbutton conditioner: 2-flop synchroniser, counter-driven debounce FSM,
// and registered level / press / release / long-press events plus a wrapping press count.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 120_000,
    parameter int LONG_CYCLES     = 12_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES - 1);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic          sync1_q, sync2_q;
    logic          sync_in;
    logic [1:0]    state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic          long_done_q, long_done_d;
    logic          pressed_q, pressed_d;
    logic          press_pulse_q, press_pulse_d;
    logic          release_pulse_q, release_pulse_d;
    logic          long_pulse_q, long_pulse_d;
    logic [7:0]    press_count_q, press_count_d;

    assign sync_in = ~sync2_q;

    always_comb begin
        state_d         = state_q;
        deb_cnt_d       = deb_cnt_q;
        long_cnt_d      = long_cnt_q;
        long_done_d     = long_done_q;
        pressed_d       = pressed_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;
        press_count_d   = press_count_q;

        case (state_q)
            IDLE: begin
                if (sync_in) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_in) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d       = HELD;
                    pressed_d     = 1'b1;
                    press_pulse_d = 1'b1;
                    press_count_d = press_count_q + 8'd1;
                    long_cnt_d    = '0;
                    long_done_d   = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!sync_in) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync_in) begin
                    state_d = HELD;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d         = IDLE;
                    pressed_d       = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Release glitches keep the long-press timer running; it parks at its max so long fires once.
        if (state_q == HELD || state_q == RELEASE_WAIT) begin
            if (long_cnt_q != LONG_MAX) long_cnt_d = long_cnt_q + 1'b1;
            if (long_cnt_q == LONG_MAX && !long_done_q) begin
                long_pulse_d = 1'b1;
                long_done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            state_q         <= IDLE;
            deb_cnt_q       <= '0;
            long_cnt_q      <= '0;
            long_done_q     <= 1'b0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            press_count_q   <= 8'd0;
        end else begin
            sync1_q         <= btn_n;
            sync2_q         <= sync1_q;
            state_q         <= state_d;
            deb_cnt_q       <= deb_cnt_d;
            long_cnt_q      <= long_cnt_d;
            long_done_q     <= long_done_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
            press_count_q   <= press_count_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: expected events are queued as stimulus is driven and
// matched against events captured from the DUT outputs, by edge number.
module tb_button_debouncer;

    localparam int D   = 8;
    localparam int L   = 40;
    localparam int LAT = D + 3;

    localparam logic [1:0] EV_PRESS = 2'd0;
    localparam logic [1:0] EV_REL   = 2'd1;
    localparam logic [1:0] EV_LONG  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic [7:0]  cnt;
        logic        lvl;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_n = 1'b1;
    logic       pressed, press_pulse, release_pulse, long_pulse;
    logic [7:0] press_count;

    int         cyc = 0;
    int         total = 0;
    int         passed = 0;
    logic [7:0] exp_cnt = 8'd0;
    ev_t        exp_q[$];
    ev_t        obs_q[$];

    button_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n),
        .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .press_count(press_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input logic [1:0] k, input int c, input logic [7:0] n, input logic l);
        ev_t e;
        e.kind = k;
        e.cyc  = 32'(c);
        e.cnt  = n;
        e.lvl  = l;
        return e;
    endfunction

    // Capture every pulse with the edge count at which it became visible.
    always @(negedge clk) begin
        if (press_pulse === 1'b1)   obs_q.push_back(mk(EV_PRESS, cyc, press_count, pressed));
        if (release_pulse === 1'b1) obs_q.push_back(mk(EV_REL, cyc, press_count, pressed));
        if (long_pulse === 1'b1)    obs_q.push_back(mk(EV_LONG, cyc, press_count, pressed));
    end

    task automatic hold(input logic lvl, input int n);
        btn_n = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 8'd0;
    endtask

    task automatic exp_press();
        exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back(mk(EV_PRESS, cyc + LAT, exp_cnt, 1'b1));
    endtask

    task automatic exp_release();
        exp_q.push_back(mk(EV_REL, cyc + LAT, exp_cnt, 1'b0));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({pressed, press_pulse, release_pulse, long_pulse, press_count} !== 12'd0)
            $display("FAIL reset_state: got %b, want all zero",
                     {pressed, press_pulse, release_pulse, long_pulse, press_count});
        else passed++;
        hold(1'b1, 2);
        rst = 1'b0;
        hold(1'b1, 100);
        total++;
        if ({pressed, press_pulse, release_pulse, long_pulse, press_count} !== 12'd0)
            $display("FAIL idle_outputs: got %b, want all zero",
                     {pressed, press_pulse, release_pulse, long_pulse, press_count});
        else passed++;
        total++;
        if (obs_q.size() != 0) begin
            $display("FAIL idle_no_pulses: got %0d events, want 0", obs_q.size());
            obs_q.delete();
        end else passed++;
    endtask

    task automatic test_press_release();
        ev_t e, o;
        exp_press();
        hold(1'b0, 30);
        total++;
        if (pressed !== 1'b1 || press_count !== exp_cnt)
            $display("FAIL held_level: got pressed=%b cnt=%0d, want 1 cnt=%0d", pressed, press_count, exp_cnt);
        else passed++;
        exp_release();
        hold(1'b1, 20);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0)
                $display("FAIL press_release_event: got none, want k=%0d c=%0d", e.kind, e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("FAIL press_release_event: got k=%0d c=%0d n=%0d l=%0d, want k=%0d c=%0d n=%0d l=%0d",
                             o.kind, o.cyc, o.cnt, o.lvl, e.kind, e.cyc, e.cnt, e.lvl);
                else passed++;
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            $display("FAIL press_release_extra: got %0d extra events, want 0", obs_q.size());
            obs_q.delete();
        end else passed++;
    endtask

    task automatic test_bounce();
        ev_t e, o;
        do_reset();
        hold(1'b1, 10);
        hold(1'b0, 5);
        hold(1'b1, 2);
        hold(1'b0, 3);
        hold(1'b1, 4);
        exp_press();
        hold(1'b0, 30);
        exp_release();
        hold(1'b1, 20);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0)
                $display("FAIL bounce_event: got none, want k=%0d c=%0d", e.kind, e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("FAIL bounce_event: got k=%0d c=%0d n=%0d l=%0d, want k=%0d c=%0d n=%0d l=%0d",
                             o.kind, o.cyc, o.cnt, o.lvl, e.kind, e.cyc, e.cnt, e.lvl);
                else passed++;
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            $display("FAIL bounce_extra: got %0d extra events, want 0", obs_q.size());
            obs_q.delete();
        end else passed++;
    endtask

    task automatic test_long();
        ev_t e, o;
        do_reset();
        hold(1'b1, 10);
        exp_press();
        // pressed rises at +LAT, long fires L edges later
        exp_q.push_back(mk(EV_LONG, cyc + LAT + L, exp_cnt, 1'b1));
        hold(1'b0, 45);
        hold(1'b1, 2);
        hold(1'b0, 23);
        exp_release();
        hold(1'b1, 20);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0)
                $display("FAIL long_event: got none, want k=%0d c=%0d", e.kind, e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("FAIL long_event: got k=%0d c=%0d n=%0d l=%0d, want k=%0d c=%0d n=%0d l=%0d",
                             o.kind, o.cyc, o.cnt, o.lvl, e.kind, e.cyc, e.cnt, e.lvl);
                else passed++;
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            $display("FAIL long_extra: got %0d extra events, want 0", obs_q.size());
            obs_q.delete();
        end else passed++;
    endtask

    task automatic test_wrap();
        ev_t e, o;
        do_reset();
        hold(1'b1, 10);
        for (int i = 0; i < 256; i++) begin
            exp_press();
            hold(1'b0, 12);
            exp_release();
            hold(1'b1, 12);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0)
                $display("FAIL wrap_event: got none, want k=%0d c=%0d", e.kind, e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("FAIL wrap_event: got k=%0d c=%0d n=%0d l=%0d, want k=%0d c=%0d n=%0d l=%0d",
                             o.kind, o.cyc, o.cnt, o.lvl, e.kind, e.cyc, e.cnt, e.lvl);
                else passed++;
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            $display("FAIL wrap_extra: got %0d extra events, want 0", obs_q.size());
            obs_q.delete();
        end else passed++;
        total++;
        if (press_count !== 8'd0 || pressed !== 1'b0)
            $display("FAIL wrap_final: got cnt=%0d pressed=%b, want cnt=0 pressed=0", press_count, pressed);
        else passed++;
    endtask

    task automatic test_reset_mid();
        ev_t e, o;
        do_reset();
        hold(1'b1, 10);
        exp_press();
        hold(1'b0, 15);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (pressed !== 1'b0 || press_count !== 8'd0 || release_pulse !== 1'b0)
            $display("FAIL reset_mid_state: got pressed=%b cnt=%0d rel=%b, want 0 0 0",
                     pressed, press_count, release_pulse);
        else passed++;
        rst = 1'b0;
        exp_cnt = 8'd0;
        exp_press();
        hold(1'b0, 15);
        exp_release();
        hold(1'b1, 20);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0)
                $display("FAIL reset_mid_event: got none, want k=%0d c=%0d", e.kind, e.cyc);
            else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("FAIL reset_mid_event: got k=%0d c=%0d n=%0d l=%0d, want k=%0d c=%0d n=%0d l=%0d",
                             o.kind, o.cyc, o.cnt, o.lvl, e.kind, e.cyc, e.cnt, e.lvl);
                else passed++;
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            $display("FAIL reset_mid_extra: got %0d extra events, want 0", obs_q.size());
            obs_q.delete();
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_long();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
Input-side companion to the LED colour cycler. It conditions one active-low pushbutton pin from the board into clean, single-cycle events for the 12 MHz fabric.
- Synchronises the raw pin into the clock domain.
- Debounces it with a counter-driven FSM.
- Reports a debounced level, press, release and long-press pulses, and a wrapping press count.
- Colour/mode control logic consumes these outputs to step states under user control instead of on a fixed timer.

Parameters:
DEBOUNCE_CYCLES, 120_000, cycles input must stay stable to accept a transition (10 ms at 12 MHz); must be >= 2.
LONG_CYCLES, 12_000_000, cycles after accepted press before long_pulse (1 s at 12 MHz); must be > DEBOUNCE_CYCLES.

Ports:
clk  input  1  12 MHz system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
btn_n  input  1  raw button pin, active low (0 = pressed), asynchronous to clk.
pressed  output  1  debounced level, active high.
press_pulse  output  1  one-cycle pulse on accepted press.
release_pulse  output  1  one-cycle pulse on accepted release.
long_pulse  output  1  one-cycle pulse, at most once per press.
press_count  output  8  number of accepted presses, modulo 256.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: all outputs 0; sync flops hold "released" (btn_n = 1); FSM = IDLE; counters 0; long_done = 0.
- Synchroniser: 2-flop chain on btn_n. sync_in = inverted second-flop output (1 = pressed). The FSM sees only sync_in.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES). Long counter: width $clog2(LONG_CYCLES), saturating.
- IDLE: if sync_in = 1, go to PRESS_WAIT and clear the debounce counter.
- PRESS_WAIT:
  - if sync_in = 0, return to IDLE (bounce rejected, no output change);
  - else if counter = DEBOUNCE_CYCLES-1, go to HELD, register pressed = 1 and press_pulse = 1, increment press_count (255 wraps to 0), clear the long counter and long_done;
  - else increment the counter.
- HELD:
  - if sync_in = 0, go to RELEASE_WAIT and clear the debounce counter;
  - the long counter increments every cycle in HELD and RELEASE_WAIT.
- RELEASE_WAIT:
  - if sync_in = 1, return to HELD (glitch rejected, long counter not cleared);
  - else if counter = DEBOUNCE_CYCLES-1, go to IDLE, register pressed = 0 and release_pulse = 1;
  - else increment.
- long_pulse: registered 1 on the edge where long counter = LONG_CYCLES-1 and long_done = 0; sets long_done. The long counter then saturates, so there is no repeat.
- Pulses are registered and deasserted on the following edge. press_pulse and release_pulse are never high in the same cycle.
- Latency: take edge 1 as the first edge sampling a clean new level on btn_n.
  - pressed / press_pulse appear after edge DEBOUNCE_CYCLES+3 (2 sync + 1 IDLE exit + DEBOUNCE_CYCLES count).
  - release_pulse follows the same timing.
  - long_pulse appears LONG_CYCLES edges after pressed rises.
- Any bounce shorter than DEBOUNCE_CYCLES consecutive samples produces no output change.
- Long press still ends with exactly one release_pulse.
- Reset mid-operation: outputs return to reset values on the next edge, with no release_pulse generated. If the button is still held after rst falls, it is detected as a fresh press (DEBOUNCE_CYCLES+3 latency, press_count becomes 1).
- rst has priority over all FSM activity in the same cycle.

Test Plan:
(all with DEBOUNCE_CYCLES=8, LONG_CYCLES=40)
1. Reset, btn_n=1 for 100 cycles -> all outputs 0, no pulses, press_count=0.
2. btn_n low 30 cycles then high -> pressed and press_pulse at edge 11, press_count=1; release_pulse exactly 11 edges after the first high sample, pressed=0 same cycle.
3. Bouncy press: low 5, high 2, low 3, high 4, then low 30 -> single press_pulse 11 edges after the final stable low begins; press_count=1.
4. Hold 70 cycles -> long_pulse exactly once, 40 edges after pressed rose; one release_pulse on release. A 2-cycle high glitch at cycle 45 causes no release.
5. 256 clean press/release pairs -> press_count reads 1..255 then 0; 256 press_pulses and 256 release_pulses.
6. rst asserted for 1 cycle while pressed=1 and btn_n still low -> next cycle pressed=0, press_count=0, no release_pulse; press_pulse again 11 edges after rst deasserts, press_count=1.
